// File: rtl/arb_pkg.sv
// Shared constants and types for the round-robin index arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Masked priority encoder: lowest set request at or above ptr, else lowest set request overall.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] search;

  // Keep only the requests at or above ptr; fall back to the full vector when none remain.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    masked = req & ({N_REQ{1'b1}} << ptr);
    search = (|masked) ? masked : req;
    any    = |req;
    idx    = '0;
    // Scan from the top down so the lowest set bit is the one left in idx.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (search[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter for 8 requesters producing a 3-bit winner index under valid/ready.
// Optional feature: define ARB_LOCK_EN to add the lock port, which lets the current
// owner win again on the next pick while it is still requesting.
module rr_index_arbiter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             grant_ready,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
`ifdef ARB_LOCK_EN
  ,
  input  logic             lock
`endif
);

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic             valid_n;
  logic [IDX_W-1:0] idx_n;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             hold_owner;

  rr_pick u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Decide whether the pointer stays on the current owner after its handshake.
`ifdef ARB_LOCK_EN
  assign hold_owner = lock & req[grant_idx];
`else
  assign hold_owner = 1'b0;
`endif

  // Next-state, next-pointer and next-output logic; everything holds unless a rule fires.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    valid_n = grant_valid;
    idx_n   = grant_idx;
    case (state)
      IDLE: begin
        if (pick_any) begin
          idx_n   = pick_idx;
          valid_n = 1'b1;
          state_n = GRANT;
        end
      end
      GRANT: begin
        // The grant is sticky: req is not consulted until the consumer accepts it.
        if (grant_ready) begin
          // 3-bit add wraps 7 to 0 by discarding the carry.
          ptr_n   = hold_owner ? grant_idx : grant_idx + IDX_W'(1);
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pointer and output registers; reset wins over any same-cycle handshake.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant_valid <= valid_n;
      grant_idx   <= idx_n;
    end
  end

endmodule
